// File: rtl/pool_pkg.sv
// Shared constants and width helpers for the streaming pooling engine.
package pool_pkg;

    localparam logic POOL_AVG = 1'b0;
    localparam logic POOL_MAX = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int accw(input int bw, input int kw, input int kh);
        return bw + clog2(kw * kh);
    endfunction

    function automatic int idxw(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One-channel combine unit: window init, sum or max update, final divide.
module pool_lane
    import pool_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int WIN      = 4
) (
    input  logic                                init,
    input  logic                                mode,
    input  logic [BITWIDTH+clog2(WIN)-1:0]      acc,
    input  logic [BITWIDTH-1:0]                 pix,
    output logic [BITWIDTH+clog2(WIN)-1:0]      nxt,
    output logic [BITWIDTH-1:0]                 res
);

    localparam int  ACCW = BITWIDTH + clog2(WIN);
    localparam int  SH   = clog2(WIN);
    localparam bit  POW2 = ((1 << SH) == WIN);

    logic [ACCW-1:0] pix_w;
    logic [ACCW-1:0] quot;

    assign pix_w = ACCW'(pix);

    always_comb begin
        nxt = pix_w;
        if (!init) begin
            if (mode == POOL_MAX) begin
                nxt = (pix_w > acc) ? pix_w : acc;
            end else begin
                nxt = acc + pix_w;
            end
        end
    end

    generate
        if (POW2) begin : g_shift
            assign quot = nxt >> SH;
        end else begin : g_div
            assign quot = nxt / ACCW'(WIN);
        end
    endgenerate

    // max results never exceed the sample range, so low bits are exact
    assign res = (mode == POOL_MAX) ? nxt[BITWIDTH-1:0] : quot[BITWIDTH-1:0];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming KHEIGHT x KWIDTH pooling with a one-row partial-result buffer
// and a single valid/ready output register.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int BITWIDTH    = 8,
    parameter int DATAWIDTH   = 28,
    parameter int DATAHEIGHT  = 28,
    parameter int DATACHANNEL = 3,
    parameter int KWIDTH      = 2,
    parameter int KHEIGHT     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mode,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [BITWIDTH*DATACHANNEL-1:0] s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [BITWIDTH*DATACHANNEL-1:0] m_data,
    output logic                            frame_done
);

    localparam int DW   = BITWIDTH * DATACHANNEL;
    localparam int WIN  = KWIDTH * KHEIGHT;
    localparam int ACCW = accw(BITWIDTH, KWIDTH, KHEIGHT);
    localparam int OW   = DATAWIDTH / KWIDTH;
    localparam int OH   = DATAHEIGHT / KHEIGHT;
    localparam int XW   = idxw(DATAWIDTH);
    localparam int YW   = idxw(DATAHEIGHT);
    localparam int OXW  = idxw(OW);

    localparam logic [XW-1:0] XMAX = XW'(DATAWIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(DATAHEIGHT - 1);
    localparam logic [31:0]   KWU  = 32'(KWIDTH);
    localparam logic [31:0]   KHU  = 32'(KHEIGHT);
    localparam logic [31:0]   XLIM = 32'(OW * KWIDTH);
    localparam logic [31:0]   YLIM = 32'(OH * KHEIGHT);
    localparam logic [31:0]   OWL  = 32'(OW - 1);
    localparam logic [31:0]   OHL  = 32'(OH - 1);

    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           mode_q;
    logic           out_last;
    logic [31:0]    xi;
    logic [31:0]    yi;
    logic [OXW-1:0] ox;
    logic           start;
    logic           cur_mode;
    logic           in_win;
    logic           first;
    logic           last;
    logic           frame_last;
    logic           fire;
    logic           load;
    logic [DW-1:0]  res_flat;

    logic [ACCW-1:0] rowbuf [OW][DATACHANNEL];
    logic [ACCW-1:0] nxt    [DATACHANNEL];

    assign xi         = 32'(x);
    assign yi         = 32'(y);
    assign ox         = OXW'(xi / KWU);
    assign start      = (x == '0) && (y == '0);
    assign cur_mode   = start ? mode : mode_q;
    assign in_win     = (xi < XLIM) && (yi < YLIM);
    assign first      = (xi % KWU == 0) && (yi % KHU == 0);
    assign last       = (xi % KWU == KWU - 1) && (yi % KHU == KHU - 1);
    assign frame_last = (xi / KWU == OWL) && (yi / KHU == OHL);

    assign s_ready    = !m_valid || m_ready;
    assign fire       = s_valid && s_ready;
    assign load       = fire && in_win && last;
    assign frame_done = m_valid && m_ready && out_last;

    generate
        for (genvar c = 0; c < DATACHANNEL; c++) begin : g_lane
            pool_lane #(
                .BITWIDTH (BITWIDTH),
                .WIN      (WIN)
            ) u_lane (
                .init (first),
                .mode (cur_mode),
                .acc  (rowbuf[ox][c]),
                .pix  (s_data[c*BITWIDTH +: BITWIDTH]),
                .nxt  (nxt[c]),
                .res  (res_flat[c*BITWIDTH +: BITWIDTH])
            );
        end
    endgenerate

    // completing beats go straight to the output register, not the buffer
    always_ff @(posedge clk) begin
        if (fire && in_win && !last) begin
            for (int c = 0; c < DATACHANNEL; c++) begin
                rowbuf[ox][c] <= nxt[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            mode_q   <= POOL_AVG;
            m_valid  <= 1'b0;
            m_data   <= '0;
            out_last <= 1'b0;
        end else begin
            if (fire) begin
                if (start) begin
                    mode_q <= mode;
                end
                if (x == XMAX) begin
                    x <= '0;
                    y <= (y == YMAX) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (load) begin
                m_valid  <= 1'b1;
                m_data   <= res_flat;
                out_last <= frame_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed and randomized checks of pool2d_stream against a full-frame
// reference that recomputes each window from the stored input pixels.
module tb_pool2d_stream;

    localparam int BW = 8;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int C  = 3;
    localparam int KW = 2;
    localparam int KH = 2;
    localparam int OW = W / KW;
    localparam int OH = H / KH;
    localparam int DW = BW * C;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          frame_done;

    always #5 clk = ~clk;

    pool2d_stream #(
        .BITWIDTH    (BW),
        .DATAWIDTH   (W),
        .DATAHEIGHT  (H),
        .DATACHANNEL (C),
        .KWIDTH      (KW),
        .KHEIGHT     (KH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          q[$];
    logic [DW-1:0] log_q[$];
    logic [BW-1:0] fr [H][W][C];
    int            px = 0;
    int            py = 0;
    bit            fmode = 1'b0;
    int            stall = 0;
    bit            stall_arm = 1'b0;
    bit            stalled = 1'b0;
    bit            bp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: store the frame, recompute a whole window when it completes
    task automatic model_accept(input logic [DW-1:0] d, input logic m,
                                output bit done);
        exp_t e;
        int   s;
        int   mx;
        int   v;
        int   ox;
        int   oy;
        done = 1'b0;
        if (px == 0 && py == 0) fmode = m;
        for (int c = 0; c < C; c++) fr[py][px][c] = d[c*BW +: BW];
        if (px % KW == KW - 1 && py % KH == KH - 1 &&
            px < OW * KW && py < OH * KH) begin
            ox = px / KW;
            oy = py / KH;
            e.d = '0;
            for (int c = 0; c < C; c++) begin
                s  = 0;
                mx = 0;
                for (int ky = 0; ky < KH; ky++) begin
                    for (int kx = 0; kx < KW; kx++) begin
                        v = int'(fr[oy*KH+ky][ox*KW+kx][c]);
                        s += v;
                        if (v > mx) mx = v;
                    end
                end
                e.d[c*BW +: BW] = BW'(fmode ? mx : s / (KW * KH));
            end
            e.last = (ox == OW - 1) && (oy == OH - 1);
            q.push_back(e);
            done = 1'b1;
        end
        px++;
        if (px == W) begin
            px = 0;
            py++;
            if (py == H) py = 0;
        end
    endtask

    task automatic set_ready();
        if (stall_arm && m_valid) begin
            stall     = 5;
            stall_arm = 1'b0;
        end
        if (stall > 0) begin
            m_ready = 1'b0;
            stalled = 1'b1;
            stall--;
        end else begin
            stalled = 1'b0;
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic m);
        bit done;
        bit ok;
        ok      = 1'b0;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        mode    = m;
        for (int t = 0; t < 100 && !ok; t++) begin
            set_ready();
            @(negedge clk);
            if (s_ready) begin
                model_accept(d, m, done);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("accept", 32'(ok), 1);
        if (done) chk("latency_mvalid", 32'(m_valid), 1);
    endtask

    task automatic send_frame(input int kind, input logic m, input int npix,
                              input bit toggle);
        for (int p = 0; p < npix; p++) begin
            logic [DW-1:0] d;
            logic          bm;
            for (int c = 0; c < C; c++) begin
                case (kind)
                    0:       d[c*BW +: BW] = BW'(p + 10 * c);
                    1:       d[c*BW +: BW] = 8'hFF;
                    2:       d[c*BW +: BW] = (c == 1) ? 8'd1 : 8'd0;
                    default: d[c*BW +: BW] = BW'($urandom);
                endcase
            end
            bm = (p == 0 || !toggle) ? m : 1'($urandom_range(0, 1));
            beat(d, bm);
        end
    endtask

    task automatic drain();
        s_valid = 1'b0;
        for (int t = 0; t < 300 && (q.size() > 0 || stall > 0); t++) begin
            set_ready();
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(q.size()), 0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        stall   = 0;
        stalled = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        px = 0;
        py = 0;
    endtask

    task automatic check_log4(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        int e[4];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        e[3] = e3;
        chk({tag, "_count"}, 32'(log_q.size()), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk(tag, 32'(log_q[i][BW-1:0]), 32'(e[i]));
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] v);
        chk({tag, "_count"}, 32'(log_q.size()), 4);
        for (int i = 0; i < log_q.size(); i++) chk(tag, 32'(log_q[i]), 32'(v));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            bit fd;
            fd = 1'b0;
            if (m_valid) begin
                chk("out_pending", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    chk("m_data", 32'(m_data), 32'(q[0].d));
                    fd = m_ready && q[0].last;
                end
            end
            chk("frame_done", 32'(frame_done), 32'(fd));
            if (stalled) begin
                chk("stall_sready", 32'(s_ready), 0);
                chk("stall_hold", 32'(m_data[BW-1:0]), 3);
            end
            if (m_valid && m_ready && q.size() > 0) begin
                log_q.push_back(m_data);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst     = 1'b1;
        mode    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        do_reset();
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        log_q.delete();
        send_frame(0, 1'b0, W * H, 1'b0);
        drain();
        check_log4("avg_ramp", 3, 5, 13, 15);

        log_q.delete();
        send_frame(0, 1'b1, W * H, 1'b0);
        drain();
        check_log4("max_ramp", 6, 8, 16, 18);

        log_q.delete();
        send_frame(1, 1'b0, W * H, 1'b0);
        drain();
        check_all("avg_255", {DW{1'b1}});

        log_q.delete();
        send_frame(2, 1'b0, W * H, 1'b0);
        drain();
        check_all("avg_ch1", 24'h000100);

        log_q.delete();
        stall_arm = 1'b1;
        send_frame(0, 1'b0, W * H, 1'b0);
        drain();
        check_log4("bp_ramp", 3, 5, 13, 15);

        send_frame(0, 1'b0, 6, 1'b0);
        do_reset();
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 1);
        log_q.delete();
        send_frame(0, 1'b1, W * H, 1'b1);
        drain();
        check_log4("rst_max_ramp", 6, 8, 16, 18);

        bp = 1'b1;
        for (int f = 0; f < 8; f++) begin
            send_frame(3, 1'($urandom_range(0, 1)), W * H, 1'b1);
        end
        drain();
        bp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Streaming 2-D pooling engine: accepts one pixel per handshake (all channels in parallel) in raster order and emits one pooled pixel per completed KHEIGHT×KWIDTH window.

- Successor to the combinational full-frame average pool, with these differences:
  - holds only one row of partial results instead of a flattened frame;
  - selects max or average at run time;
  - supports valid/ready backpressure.
- Sits between a convolution/activation stage and the next layer in the CNN datapath.

## Interface
- BITWIDTH, 8: unsigned sample width per channel.
- DATAWIDTH, 28: input frame width in pixels.
- DATAHEIGHT, 28: input frame height in pixels.
- DATACHANNEL, 3: channels carried in parallel per pixel.
- KWIDTH, 2: window width; horizontal stride equals KWIDTH.
- KHEIGHT, 2: window height; vertical stride equals KHEIGHT.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = average, 1 = max. Sampled only on the accepted beat of pixel (0,0) of each frame.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input ready.
- s_data  in  BITWIDTH*DATACHANNEL  pixel; channel c occupies bits [c*BITWIDTH +: BITWIDTH].
- m_valid  out  1  output pixel valid.
- m_ready  in  1  output ready.
- m_data  out  BITWIDTH*DATACHANNEL  pooled pixel, same channel packing as s_data.
- frame_done  out  1  one-cycle pulse with the last output beat of a frame, asserted in the cycle that beat transfers.

## Operation
- **Output grid:** OW = DATAWIDTH/KWIDTH and OH = DATAHEIGHT/KHEIGHT, both floor division.
  - Trailing columns (x ≥ OW*KWIDTH) and rows (y ≥ OH*KHEIGHT) are still accepted but ignored.
- **Counters:**
  - x counts 0..DATAWIDTH-1; y counts 0..DATAHEIGHT-1.
  - Both wrap to 0 after (DATAWIDTH-1, DATAHEIGHT-1); the next beat starts a new frame.
- **Accumulator width:** ACCW = BITWIDTH + clog2(KWIDTH*KHEIGHT) per channel.
- **Partial-row buffer:** OW entries × DATACHANNEL × ACCW. Entry ox holds the running result of window column ox.
- **Per accepted in-window beat, with ox = x/KWIDTH:**
  - First pixel of a window (x%KWIDTH==0 and y%KHEIGHT==0): entry is overwritten with the pixel value.
  - Otherwise the entry is updated: average mode entry += pixel; max mode entry = max(entry, pixel).
- **Window completion:** on the bottom-right pixel, the combined value goes to the output register instead of being written back.
  - Average: sum / (KWIDTH*KHEIGHT), truncated. Use a right shift when the product is a power of two.
  - Max: value passes through unchanged.
- **Mode latch:** mode is captured at frame start and held for the whole frame.
- **Counter state:** x, y, latched mode; no other FSM states.

## Timing
- Reset values: s_ready=1, m_valid=0, m_data=0, frame_done=0, x=y=0, mode latch=0. Buffer contents are don't-care.
- A transfer occurs when valid and ready are both high in the same cycle.
- s_ready = !m_valid || m_ready, combinational. Stalling depends only on the output register, never on window position.
- Latency: m_valid rises in the cycle after the window-completing input beat transfers.
- m_valid/m_data hold stable until m_ready. A new result may load in the same cycle an old one drains, giving full throughput.
- Simultaneous accept + drain: output register takes the new value and m_valid stays 1.
- rst mid-frame: counters and output register clear; the next accepted beat is pixel (0,0) of a new frame.
- Throughput: one input pixel per cycle when m_ready is held high.

## Structure
- **Package pool_pkg:**
  - mode constants POOL_AVG=0, POOL_MAX=1;
  - clog2 function;
  - ACCW derivation.
- **Sub-module pool_lane:** one-channel combine unit (init / add / max / finalize-divide), instantiated DATACHANNEL times.
- **Top level:** counters, mode latch, partial-row buffer (register array; RAM inference allowed), output register, handshake.

## Test plan
- 4×4×1, 2×2, avg, input 0..15 raster, m_ready=1 → m_data 2, 4, 10, 12; frame_done with the 4th beat.
- Same stimulus, max mode → 5, 7, 13, 15.
- 5×5×1, 2×2, avg, input 0..24 → 4 outputs (3, 5, 13, 15); column 4 and row 4 dropped; next frame starts cleanly at (0,0).
- 4×4×3, all channels 255, avg → every channel 255, no overflow; channel 1 = 1, others 0 → channel 1 = 1, others 0.
- Backpressure: m_ready low for 5 cycles after the first output → m_data held 2, s_ready low while m_valid; resumes with no pixel lost or duplicated.
- Reset asserted after 6 pixels of a frame, then frame 0..15 in max mode → outputs 5, 7, 13, 15. Mode toggled mid-frame has no effect until the next frame.
